// File: rtl/mult_pkg.sv
// mult_pkg
//   Shared types and constants for the add-shift multiplier sequencer.
//   mult_state_t : sequencer state encoding
//   MULT_WIDTH   : default operand width of the multiplier datapath
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADB = 3'd1,
    START = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } mult_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// mult_iter_counter
//   Iteration counter for the multiplier sequencer. Synchronous clear has
//   priority over enable. o_last flags the final iteration (count == WIDTH-1).
//   Ports:
//     Clk     in  system clock, rising edge
//     Reset   in  asynchronous active-low reset
//     i_clr   in  clear count to 0
//     i_en    in  increment count
//     o_count out current count
//     o_last  out count == WIDTH-1
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     i_clr,
  input  logic                     i_en,
  output logic [$clog2(WIDTH)-1:0] o_count,
  output logic                     o_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)     r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_last  = (r_count == LAST);

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer
//   Control sequencer for the 8-bit signed add-shift multiplier. Converts the
//   synchronized ClearA_LoadB / Run buttons into one-cycle datapath strobes and
//   runs exactly WIDTH add/shift iterations per Run press.
//   Parameters:
//     WIDTH      operand width, sets iteration count (>= 2)
//     CLR_ON_RUN 1 = clear X:A in a START cycle before iteration 0
//   Ports:
//     Clk, Reset    clock / async active-low reset
//     ClearA_LoadB  in  clear X:A and load B (honoured in IDLE only)
//     Run           in  Execute level
//     M             in  current multiplier LSB (B[0])
//     Ld_B          out load B from switches
//     Clr_XA        out clear X and A
//     Ld_XA         out load adder result into X:A (M-qualified, ADD only)
//     Sub_Add       out 1 = subtract on the final iteration
//     Shift_En      out arithmetic right shift of X:A:B
//     Busy          out multiplication in progress
//     Done          out product valid, held until Run released
//     Count         out completed shift count (debug)
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter bit CLR_ON_RUN = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     ClearA_LoadB,
  input  logic                     Run,
  input  logic                     M,
  output logic                     Ld_B,
  output logic                     Clr_XA,
  output logic                     Ld_XA,
  output logic                     Sub_Add,
  output logic                     Shift_En,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(WIDTH)-1:0] Count
);

  mult_state_t r_state;
  mult_state_t w_next;
  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic        w_last;

  mult_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (Count),
    .o_last  (w_last)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Outputs are decoded from state alone (Ld_XA also follows M), so the
  // async reset forces every strobe low without waiting for a clock edge.
  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    Ld_B      = 1'b0;
    Clr_XA    = 1'b0;
    Ld_XA     = 1'b0;
    Sub_Add   = 1'b0;
    Shift_En  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // ClearA_LoadB wins over Run in the same cycle.
        if (ClearA_LoadB) begin
          w_next = LOADB;
        end else if (Run) begin
          w_next    = CLR_ON_RUN ? START : ADD;
          w_cnt_clr = 1'b1;
        end
      end
      LOADB: begin
        Ld_B   = 1'b1;
        Clr_XA = 1'b1;
        w_next = IDLE;
      end
      START: begin
        Clr_XA = 1'b1;
        Busy   = 1'b1;
        w_next = ADD;
      end
      ADD: begin
        // Sub_Add is driven even when M=0; it is harmless without Ld_XA.
        Ld_XA   = M;
        Sub_Add = w_last;
        Busy    = 1'b1;
        w_next  = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        // The last shift leaves Count at WIDTH-1 rather than wrapping to 0.
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_cnt_en = 1'b1;
          w_next   = ADD;
        end
      end
      DONE: begin
        Done = 1'b1;
        // Holding Run keeps us here so one press yields one product.
        if (!Run) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       cl = 1'b0, run = 1'b0, m = 1'b0;

  logic       d1_ldb, d1_clr, d1_ldx, d1_sub, d1_sh, d1_bsy, d1_dn;
  logic [2:0] d1_cnt;
  logic       d0_ldb, d0_clr, d0_ldx, d0_sub, d0_sh, d0_bsy, d0_dn;
  logic [2:0] d0_cnt;

  mult_sequencer #(.WIDTH(8), .CLR_ON_RUN(1'b1)) u_dut (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(cl), .Run(run), .M(m),
    .Ld_B(d1_ldb), .Clr_XA(d1_clr), .Ld_XA(d1_ldx), .Sub_Add(d1_sub),
    .Shift_En(d1_sh), .Busy(d1_bsy), .Done(d1_dn), .Count(d1_cnt)
  );

  mult_sequencer #(.WIDTH(8), .CLR_ON_RUN(1'b0)) u_dut_nc (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(cl), .Run(run), .M(m),
    .Ld_B(d0_ldb), .Clr_XA(d0_clr), .Ld_XA(d0_ldx), .Sub_Add(d0_sub),
    .Shift_En(d0_sh), .Busy(d0_bsy), .Done(d0_dn), .Count(d0_cnt)
  );

  always #5 Clk = ~Clk;

  wire [6:0] o1 = {d1_ldb, d1_clr, d1_ldx, d1_sub, d1_sh, d1_bsy, d1_dn};
  wire [6:0] o0 = {d0_ldb, d0_clr, d0_ldx, d0_sub, d0_sh, d0_bsy, d0_dn};

  localparam logic [6:0] LDB = 7'b1000000, CLR = 7'b0100000, LDX = 7'b0010000,
                         SUB = 7'b0001000, SH  = 7'b0000100, BSY = 7'b0000010,
                         DN  = 7'b0000001, NONE = 7'b0000000;

  typedef struct {
    logic       cl, run, m;
    logic [6:0] exp;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0, n_fail = 0;

  int busy1, busy0, sh1, sh0, sub1, ldx1, ldb1, ldb0, clr1, dn1, dn0, first1, first0;
  logic d40, d41, b41;

  function automatic void v(input logic c, input logic r, input logic mm,
                            input logic [6:0] e, input logic [2:0] n);
    vec_t t;
    t.cl = c; t.run = r; t.m = mm; t.exp = e; t.cnt = n;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0; cl = 1'b0; run = 1'b0; m = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic clr_tally();
    busy1 = 0; busy0 = 0; sh1 = 0; sh0 = 0; sub1 = 0; ldx1 = 0;
    ldb1 = 0; ldb0 = 0; clr1 = 0; dn1 = 0; dn0 = 0; first1 = -1; first0 = -1;
  endtask

  task automatic tally(input int c);
    busy1 += int'(d1_bsy); busy0 += int'(d0_bsy);
    sh1 += int'(d1_sh); sh0 += int'(d0_sh);
    sub1 += int'(d1_sub); ldx1 += int'(d1_ldx);
    ldb1 += int'(d1_ldb); ldb0 += int'(d0_ldb); clr1 += int'(d1_clr);
    dn1 += int'(d1_dn); dn0 += int'(d0_dn);
    if (d1_dn && first1 < 0) first1 = c;
    if (d0_dn && first0 < 0) first0 = c;
  endtask

  initial begin
    // Per-cycle vectors: inputs for the cycle and the outputs expected in it.
    v(0,0,0, NONE,    0);  // IDLE after reset
    v(1,0,0, NONE,    0);  // IDLE, ClearA_LoadB seen
    v(0,0,0, LDB|CLR, 0);  // LOADB
    v(0,0,0, NONE,    0);  // back to IDLE, no Busy
    v(1,1,0, NONE,    0);  // both high in IDLE
    v(0,1,0, LDB|CLR, 0);  // LOADB wins
    v(0,1,0, NONE,    0);  // IDLE, Run still held -> START
    v(0,0,1, CLR|BSY, 0);  // START (k+1)
    v(0,0,1, LDX|BSY, 0);  v(0,0,1, SH|BSY, 0);  // iter 0, M=1
    v(0,0,0, BSY,     1);  v(0,0,1, SH|BSY, 1);  // iter 1, M=0
    v(0,0,1, LDX|BSY, 2);  v(0,0,1, SH|BSY, 2);  // iter 2, M=1
    v(0,0,1, LDX|BSY, 3);  v(0,0,1, SH|BSY, 3);  // iter 3, M=1
    v(0,0,0, BSY,     4);  v(0,0,1, SH|BSY, 4);  // iter 4, M=0
    v(0,0,0, BSY,     5);  v(0,0,1, SH|BSY, 5);  // iter 5, M=0
    v(0,0,1, LDX|BSY, 6);  v(0,0,1, SH|BSY, 6);  // iter 6, M=1
    v(0,0,1, LDX|SUB|BSY, 7); v(0,0,1, SH|BSY, 7); // iter 7, subtract
    v(0,0,0, DN,      7);  // DONE at k+18, Run already low
    v(0,0,0, NONE,    7);  // IDLE: Done lasted one cycle, Count held

    // Reset state, checked while reset is asserted.
    @(negedge Clk); #1;
    chk("reset_outputs", o1, NONE);
    chk("reset_count", d1_cnt, 0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge Clk);
      cl = tbl[i].cl; run = tbl[i].run; m = tbl[i].m;
      #1;
      chk($sformatf("vec%0d_out", i), o1, tbl[i].exp);
      chk($sformatf("vec%0d_cnt", i), d1_cnt, tbl[i].cnt);
    end

    // Run held for 40 cycles: only one multiplication, Done held until release.
    do_reset();
    clr_tally();
    d40 = 1'b0; d41 = 1'b1; b41 = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge Clk);
      run = (c < 40); m = 1'b1;
      #1;
      tally(c);
      if (c == 40) d40 = d1_dn;
      if (c == 41) begin d41 = d1_dn; b41 = d1_bsy; end
    end
    chk("held_busy_cycles", busy1, 17);
    chk("held_shifts", sh1, 8);
    chk("held_sub_pulses", sub1, 1);
    chk("held_done_rise", first1, 18);
    chk("held_done_cycles", dn1, 23);
    chk("held_done_at_release", d40, 1'b1);
    chk("held_idle_after_release", {d41, b41}, 2'b00);
    chk("noclr_busy_cycles", busy0, 16);
    chk("noclr_shifts", sh0, 8);
    chk("noclr_done_rise", first0, 17);
    chk("noclr_done_cycles", dn0, 24);

    // ClearA_LoadB while Busy is ignored and not queued.
    do_reset();
    clr_tally();
    for (int c = 0; c < 25; c++) begin
      @(negedge Clk);
      run = (c == 0); cl = (c >= 3 && c <= 12); m = 1'b0;
      #1;
      tally(c);
    end
    chk("busy_clr_no_ldb", ldb1, 0);
    chk("busy_clr_no_ldb_nc", ldb0, 0);
    chk("busy_clr_clrxa_once", clr1, 1);
    chk("busy_clr_shifts", sh1, 8);
    chk("busy_clr_done_rise", first1, 18);
    chk("m0_no_ldxa", ldx1, 0);
    chk("m0_sub_still_driven", sub1, 1);

    // Reset asserted mid-SHIFT of iteration 3.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      run = (c == 0); m = 1'b1;
      #1;
    end
    chk("pre_reset_shift3", {o1, d1_cnt}, {SH|BSY, 3'd3});
    #2 Reset = 1'b0;
    #1;
    chk("async_reset_out", o1, NONE);
    chk("async_reset_cnt", d1_cnt, 0);
    chk("async_reset_out_nc", o0, NONE);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk); #1;
    chk("post_reset_idle", {o1, d1_cnt}, {NONE, 3'd0});
    run = 1'b1;
    @(negedge Clk);
    run = 1'b0; #1;
    chk("post_reset_start", {o1, d1_cnt}, {CLR|BSY, 3'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
